// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_disp_pkg;

    typedef enum logic {
        S_DRIVE = 1'b0,
        S_GUARD = 1'b1
    } scan_state_t;

    // Common-anode digits: a high anode line means the digit is dark.
    localparam logic ANODE_OFF = 1'b1;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/refresh_tick_gen.sv
// Slot counter: flags the last cycle of the drive and guard phases of a digit slot.
module refresh_tick_gen
    import seg_disp_pkg::*;
#(
    parameter int DRIVE_LEN = 6,
    parameter int GUARD_LEN = 2,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  scan_state_t i_state,
    output logic        o_last_drive,
    output logic        o_last_guard
);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_last_drive = (i_state == S_DRIVE) && (r_cnt == DRIVE_LAST);
    assign o_last_guard = (i_state == S_GUARD) && (r_cnt == GUARD_LAST);

    // The count restarts on every phase change, so each phase is timed from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (o_last_drive || o_last_guard) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed scan controller for common-anode seven-segment digits with
// double-buffered value, leading-zero blanking, per-digit masking and guard gaps.
//
//   state   | meaning
//   S_DRIVE | current digit may be lit (subject to blanking)
//   S_GUARD | all anodes off before moving to the next digit
module seven_seg_scanner
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter bit LZ_BLANK_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask_in,
    input  logic                    value_valid,
    output logic                    value_ready,
    output logic [3:0]              hex_digit_out,
    output logic                    digit_blank_out,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             r_state;
    scan_state_t             w_state_next;
    logic                    w_last_drive;
    logic                    w_last_guard;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_mask;
    logic                    r_pend_full;
    logic [4*NUM_DIGITS-1:0] r_shadow_value;
    logic [NUM_DIGITS-1:0]   r_shadow_mask;
    logic                    w_accept;
    logic                    w_frame_end;
    logic                    w_upper_zero;
    logic [NUM_DIGITS-1:0]   w_lz_zero;
    logic                    w_blank;
    nibble_t                 w_nibble;

    refresh_tick_gen #(
        .DRIVE_LEN (REFRESH_DIV - GUARD_CYCLES),
        .GUARD_LEN (GUARD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_state      (r_state),
        .o_last_drive (w_last_drive),
        .o_last_guard (w_last_guard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_GUARD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_DRIVE: if (w_last_drive) w_state_next = S_GUARD;
            S_GUARD: if (w_last_guard) w_state_next = S_DRIVE;
            default: w_state_next = S_GUARD;
        endcase
    end

    assign w_frame_end = w_last_guard && (r_digit_idx == LAST_IDX);
    assign frame_done  = w_frame_end;
    assign value_ready = !r_pend_full;
    assign w_accept    = value_valid && !r_pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_idx <= LAST_IDX;
        end else if (w_last_guard) begin
            r_digit_idx <= (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;
        end
    end

    // Accept and frame-boundary promotion are exclusive: accept needs an empty buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_value   <= '0;
            r_pend_mask    <= '0;
            r_pend_full    <= 1'b0;
            r_shadow_value <= '0;
            r_shadow_mask  <= '0;
        end else if (w_accept) begin
            r_pend_value <= value_in;
            r_pend_mask  <= blank_mask_in;
            r_pend_full  <= 1'b1;
        end else if (w_frame_end && r_pend_full) begin
            r_shadow_value <= r_pend_value;
            r_shadow_mask  <= r_pend_mask;
            r_pend_full    <= 1'b0;
        end
    end

    // w_lz_zero[i] is set when nibbles i..NUM_DIGITS-1 of the shadow are all zero.
    always_comb begin
        w_lz_zero    = '0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_shadow_value[4*i +: 4] == 4'h0);
            w_lz_zero[i] = w_upper_zero;
        end
    end

    assign w_nibble = r_shadow_value[{r_digit_idx, 2'b00} +: 4];
    assign w_blank  = (r_state == S_GUARD)
                    || r_shadow_mask[r_digit_idx]
                    || (LZ_BLANK_EN && (r_digit_idx != '0) && w_lz_zero[r_digit_idx]);

    always_comb begin
        anode_out       = {NUM_DIGITS{ANODE_OFF}};
        digit_blank_out = 1'b1;
        hex_digit_out   = 4'h0;
        if (!w_blank) begin
            anode_out       = ~(NUM_DIGITS'(1) << r_digit_idx);
            digit_blank_out = 1'b0;
            hex_digit_out   = w_nibble;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 8-cycle slots, 2-cycle guard.
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  blank_mask_in;
    logic        value_valid;

    logic        value_ready, digit_blank_out, frame_done;
    logic [3:0]  hex_digit_out, anode_out;
    logic        ready_b, blank_b, done_b;
    logic [3:0]  hex_b, anode_b;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .LZ_BLANK_EN(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .blank_mask_in(blank_mask_in),
        .value_valid(value_valid), .value_ready(value_ready), .hex_digit_out(hex_digit_out),
        .digit_blank_out(digit_blank_out), .anode_out(anode_out), .frame_done(frame_done)
    );

    seven_seg_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD_CYCLES(2), .LZ_BLANK_EN(1'b0)
    ) u_dut_nolz (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .blank_mask_in(blank_mask_in),
        .value_valid(value_valid), .value_ready(ready_b), .hex_digit_out(hex_b),
        .digit_blank_out(blank_b), .anode_out(anode_b), .frame_done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic slot(input string tag, input logic [3:0] an, input logic bl, input logic [3:0] hx);
        chk({tag, "_anode"}, {12'h0, anode_out}, {12'h0, an});
        chk({tag, "_blank"}, {15'h0, digit_blank_out}, {15'h0, bl});
        chk({tag, "_hex"}, {12'h0, hex_digit_out}, {12'h0, hx});
    endtask

    task automatic slot_b(input string tag, input logic [3:0] an, input logic bl, input logic [3:0] hx);
        chk({tag, "_anode"}, {12'h0, anode_b}, {12'h0, an});
        chk({tag, "_blank"}, {15'h0, blank_b}, {15'h0, bl});
        chk({tag, "_hex"}, {12'h0, hex_b}, {12'h0, hx});
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk(tag, {15'h0, value_ready}, {15'h0, exp});
    endtask

    task automatic chk_done(input string tag, input logic exp);
        chk(tag, {15'h0, frame_done}, {15'h0, exp});
    endtask

    initial begin
        rst_n         = 1'b0;
        value_in      = 16'h0;
        blank_mask_in = 4'h0;
        value_valid   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        slot("rst", 4'hF, 1'b1, 4'h0);
        chk_ready("rst_ready", 1'b1);
        chk_done("rst_done", 1'b0);
        slot_b("rst_nolz", 4'hF, 1'b1, 4'h0);

        // Release: cycles 0-1 are the guard of digit 3, cycle 1 ends the first frame.
        rst_n = 1'b1;
        cyc   = 0;
        slot("c0_guard", 4'hF, 1'b1, 4'h0);
        goto(1);   chk_done("c1_done", 1'b1);
        goto(2);   slot("c2_d0", 4'hE, 1'b0, 4'h0); chk_done("c2_done", 1'b0);
        goto(7);   slot("c7_d0", 4'hE, 1'b0, 4'h0);
        goto(8);   slot("c8_guard", 4'hF, 1'b1, 4'h0);
        goto(10);  slot("c10_d1_lz", 4'hF, 1'b1, 4'h0); slot_b("c10_nolz_d1", 4'hD, 1'b0, 4'h0);

        // Load 1234 one cycle before the frame boundary at cycle 33.
        goto(32);  value_in = 16'h1234; value_valid = 1'b1; chk_ready("c32_ready", 1'b1);
        goto(33);  value_valid = 1'b0; chk_ready("c33_ready", 1'b0); chk_done("c33_done", 1'b1);
        goto(34);  chk_ready("c34_ready", 1'b1); slot("c34_d0", 4'hE, 1'b0, 4'h4);
        goto(39);  slot("c39_d0", 4'hE, 1'b0, 4'h4);
        goto(40);  slot("c40_guard", 4'hF, 1'b1, 4'h0);
        value_in = 16'h00A0; value_valid = 1'b1;
        goto(41);  value_valid = 1'b0; chk_ready("c41_ready", 1'b0);
        goto(42);  slot("c42_d1", 4'hD, 1'b0, 4'h3);
        goto(50);  slot("c50_d2_still1234", 4'hB, 1'b0, 4'h2);
        goto(58);  slot("c58_d3", 4'h7, 1'b0, 4'h1);
        goto(64);  chk_done("c64_done", 1'b0);
        goto(65);  chk_done("c65_done", 1'b1);

        // 00A0 frame (66-97): LZ blanks digits 2-3 only on the LZ-enabled instance.
        goto(66);  slot("c66_d0", 4'hE, 1'b0, 4'h0); slot_b("c66_nolz_d0", 4'hE, 1'b0, 4'h0);
        goto(70);  value_in = 16'h1111; value_valid = 1'b1; chk_ready("c70_ready", 1'b1);
        goto(71);  value_in = 16'h2222; chk_ready("c71_ready", 1'b0);
        goto(74);  slot("c74_d1", 4'hD, 1'b0, 4'hA); slot_b("c74_nolz_d1", 4'hD, 1'b0, 4'hA);
        goto(82);  slot("c82_d2_lz", 4'hF, 1'b1, 4'h0); slot_b("c82_nolz_d2", 4'hB, 1'b0, 4'h0);
        goto(90);  slot("c90_d3_lz", 4'hF, 1'b1, 4'h0); slot_b("c90_nolz_d3", 4'h7, 1'b0, 4'h0);
        goto(97);  chk_ready("c97_ready", 1'b0); chk_done("c97_done", 1'b1);
        goto(98);  chk_ready("c98_ready", 1'b1); slot("c98_d0", 4'hE, 1'b0, 4'h1);
        goto(99);  value_valid = 1'b0; chk_ready("c99_ready", 1'b0);
        goto(106); slot("c106_d1", 4'hD, 1'b0, 4'h1);
        goto(122); slot("c122_d3", 4'h7, 1'b0, 4'h1);

        // 2222 frame (130-161); mask value offered as soon as pending frees up.
        goto(130); slot("c130_d0", 4'hE, 1'b0, 4'h2); chk_ready("c130_ready", 1'b1);
        value_in = 16'h8888; blank_mask_in = 4'b0100; value_valid = 1'b1;
        goto(131); value_valid = 1'b0; blank_mask_in = 4'h0;
        goto(154); slot("c154_d3", 4'h7, 1'b0, 4'h2);

        // 8888 frame (162-193) with digit 2 masked.
        goto(162); slot("c162_d0", 4'hE, 1'b0, 4'h8);
        goto(170); slot("c170_d1", 4'hD, 1'b0, 4'h8);
        goto(178); slot("c178_d2_mask", 4'hF, 1'b1, 4'h0); slot_b("c178_nolz_mask", 4'hF, 1'b1, 4'h0);
        goto(186); slot("c186_d3", 4'h7, 1'b0, 4'h8);
        goto(190); value_in = 16'h7777; value_valid = 1'b1;
        goto(191); value_valid = 1'b0;

        // 7777 frame (194-225); 9999 parked in pending, then async reset in digit 2 drive.
        goto(200); value_in = 16'h9999; value_valid = 1'b1;
        goto(201); value_valid = 1'b0; chk_ready("c201_ready", 1'b0);
        goto(212); slot("c212_d2", 4'hB, 1'b0, 4'h7); chk_ready("c212_ready", 1'b0);
        #2 rst_n = 1'b0;
        #1;
        slot("arst", 4'hF, 1'b1, 4'h0);
        chk_ready("arst_ready", 1'b1);
        chk_done("arst_done", 1'b0);

        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        goto(2);   slot("post_c2_d0", 4'hE, 1'b0, 4'h0);
        goto(10);  slot("post_c10_d1", 4'hF, 1'b1, 4'h0);
        goto(34);  slot("post_c34_discard", 4'hE, 1'b0, 4'h0); chk_ready("post_c34_ready", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
